// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with execute-stage operand forwarding
// and load-use hazard detection for a classic 5-stage MIPS-like pipeline.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   *_d                        decode-stage operands, specifiers, control bits
//   flush_e                    turn the next stage contents into a bubble
//   hold_e                     freeze the stage register (downstream stall)
//   reg_write_m/write_reg_m/alu_out_m   memory-stage forwarding source
//   reg_write_w/write_reg_w/result_w    writeback-stage forwarding source
//   src_a_e, src_b_e, alu_control_e     ALU operands / op
//   write_data_e, write_reg_e           store data / destination register
//   reg_write_e .. valid_e              registered control and valid
//   stall_d                    combinational load-use stall to fetch/decode
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] imm_d,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rd_d,
  input  logic [2:0]       alu_control_d,
  input  logic             alu_src_d,
  input  logic             reg_dst_d,
  input  logic             reg_write_d,
  input  logic             mem_to_reg_d,
  input  logic             mem_write_d,
  input  logic             branch_d,
  input  logic             flush_e,
  input  logic             hold_e,
  input  logic             reg_write_m,
  input  logic [4:0]       write_reg_m,
  input  logic [WIDTH-1:0] alu_out_m,
  input  logic             reg_write_w,
  input  logic [4:0]       write_reg_w,
  input  logic [WIDTH-1:0] result_w,
  output logic [WIDTH-1:0] src_a_e,
  output logic [WIDTH-1:0] src_b_e,
  output logic [2:0]       alu_control_e,
  output logic [WIDTH-1:0] write_data_e,
  output logic [4:0]       write_reg_e,
  output logic             reg_write_e,
  output logic             mem_to_reg_e,
  output logic             mem_write_e,
  output logic             branch_e,
  output logic             valid_e,
  output logic             stall_d
);

  localparam logic [2:0] ALU_NOP = 3'b011;

  logic [WIDTH-1:0] r_rd1, r_rd2, r_imm;
  logic [4:0]       r_rs, r_rt, r_rd;
  logic [2:0]       r_alu_control;
  logic             r_alu_src, r_reg_dst, r_reg_write, r_mem_to_reg;
  logic             r_mem_write, r_branch, r_valid;

  logic             w_hazard, w_kill;
  logic [WIDTH-1:0] w_fwd_a, w_fwd_b;

  // Load in EX whose destination (rt) is read by the instruction in decode.
  assign w_hazard = r_valid & r_mem_to_reg & (r_rt != 5'd0) &
                    ((r_rt == rs_d) | (r_rt == rt_d));
  assign stall_d  = w_hazard & ~flush_e & ~hold_e;

  // Reset and flush override hold; the load-use bubble only applies when the
  // stage is free to advance. Flush plus hazard therefore gives one bubble.
  assign w_kill = reset | flush_e | (~hold_e & w_hazard);

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm         <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_rd          <= '0;
      r_alu_control <= ALU_NOP;
      r_alu_src     <= 1'b0;
      r_reg_dst     <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_valid       <= 1'b0;
    end else if (!hold_e) begin
      r_rd1         <= rd1_d;
      r_rd2         <= rd2_d;
      r_imm         <= imm_d;
      r_rs          <= rs_d;
      r_rt          <= rt_d;
      r_rd          <= rd_d;
      r_alu_control <= alu_control_d;
      r_alu_src     <= alu_src_d;
      r_reg_dst     <= reg_dst_d;
      r_reg_write   <= reg_write_d;
      r_mem_to_reg  <= mem_to_reg_d;
      r_mem_write   <= mem_write_d;
      r_branch      <= branch_d;
      r_valid       <= 1'b1;
    end
  end

  // Memory stage is younger than writeback, so it wins on a double match.
  // Register 0 is hardwired zero and never forwarded.
  function automatic logic [WIDTH-1:0] fwd(input logic [4:0] r,
                                           input logic [WIDTH-1:0] rf_val);
    if ((r != 5'd0) && reg_write_m && (write_reg_m == r))
      return alu_out_m;
    else if ((r != 5'd0) && reg_write_w && (write_reg_w == r))
      return result_w;
    else
      return rf_val;
  endfunction

  assign w_fwd_a = fwd(r_rs, r_rd1);
  assign w_fwd_b = fwd(r_rt, r_rd2);

  assign src_a_e       = w_fwd_a;
  assign src_b_e       = r_alu_src ? r_imm : w_fwd_b;
  assign write_data_e  = w_fwd_b;
  assign write_reg_e   = r_reg_dst ? r_rd : r_rt;
  assign alu_control_e = r_alu_control;
  assign reg_write_e   = r_reg_write;
  assign mem_to_reg_e  = r_mem_to_reg;
  assign mem_write_e   = r_mem_write;
  assign branch_e      = r_branch;
  assign valid_e       = r_valid;

endmodule
